dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  CPU-side initiator for the word-organised data memory. It accepts one byte, halfword or
//  word load/store from the execute stage. It issues word-wide requests to the memory port,
//  using read-modify-write for sub-word stores. Loads return lane-extracted, sign- or
//  zero-extended data. Misaligned or illegal requests and memory timeouts are reported as faults.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in RD/WR without mem_ready before abort (1..255)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   CPU request present
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1   loads: 1=sign-extend, 0=zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  busy        out  1   request in flight; new requests ignored
//  done        out  1   1-cycle completion pulse
//  err         out  2   valid with done: 00 ok, 01 misalign/illegal, 10 timeout
//  load_data   out  32  extended load result; updated only by a successful load
//  mem_req     out  1   memory access request
//  mem_we      out  1   memory write strobe (qualified by mem_req)
//  mem_addr    out  32  word index = {2'b00, addr[31:2]}
//  mem_wdata   out  32  full word to write
//  mem_rdata   in   32  read word, valid when mem_ready is high during a read
//  mem_ready   in   1   memory completes the current access this cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counters 0. busy, done, err, load_data, mem_req,
//   mem_we, mem_addr and mem_wdata are all 0. mem_req drops immediately, with no partial RMW write.
//  FSM states: IDLE, RD, WR, RESP.
//  Accept: req_valid & ~busy at a rising edge. Request fields are registered on accept.
//   busy=1 in RD and WR. busy=0 in IDLE and RESP, so a request can be accepted during RESP.
//  Fault check at accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
//   On fault: go to RESP with err=01. No memory access is made.
//  Load, or store of size byte/half -> RD. Word store -> WR with mem_wdata=wdata.
//  RD: mem_req=1, mem_we=0.
//   On mem_ready for a load: latch the extracted result -> RESP, err=00.
//   On mem_ready for a sub-word store: merge wdata into the returned word -> WR.
//  WR: mem_req=1, mem_we=1, holding the merged word. On mem_ready -> RESP, err=00.
//  RESP: done=1 for exactly one cycle.
//   Next state is IDLE, or a new accepted request's first state.
//  Memory-side signals are held stable while mem_req=1 and mem_ready=0.
//  Lane rules, with b=addr[1:0]:
//   byte lane = rdata[8b+7:8b].
//   half lane = rdata[16*addr[1]+15 : 16*addr[1]].
//   Extension: sign-extend if req_signed, else zero-extend. Word loads pass through.
//   Merge: replace only the addressed byte/half lanes, using wdata[7:0] or wdata[15:0].
//  Timeout: 8-bit wait counter. Cleared on entry to RD/WR and on each mem_ready.
//   It increments each RD/WR cycle that has mem_ready=0.
//   When the count reaches TIMEOUT_CYCLES: drop mem_req -> RESP with err=10.
//   A timeout in the RD phase of an RMW store performs no write. load_data is unchanged.
//  Latency from the accept edge to done with zero wait states:
//   load or word store: 2 cycles; sub-word store: 3 cycles; fault: 1 cycle.
//  mem_ready outside RD/WR is ignored. req_valid while busy is dropped, not queued.
// TESTING
//  1. Word load, addr 0x10, mem_rdata=0xDEADBEEF, ready at once:
//     mem_addr=0x4; done 2 cycles after accept; load_data=0xDEADBEEF; err=00.
//  2. Signed byte load, addr 0x13, rdata=0x80FF7F01 -> load_data=0xFFFFFF80.
//     Unsigned half load, addr 0x12, same rdata -> 0x000080FF.
//  3. Byte store 0xAA, addr 0x21, memory word 0x11223344:
//     one read, then one write of 0x1122AA44 to mem_addr=0x8; done 3 cycles after accept.
//  4. Word load, addr 0x02, and half store, addr 0x05: err=01 and done 1 cycle after
//     accept; mem_req never asserted; load_data unchanged.
//  5. TIMEOUT_CYCLES=4, mem_ready held 0: mem_req high for exactly 4 cycles, then done
//     with err=10. Then 3 wait states then ready: completes, err=00, with no timeout.
//  6. rst_n low while in WR of an RMW store: mem_req=0 at once and all outputs 0.
//     After release a word load completes normally. Also check back-to-back requests:
//     a second req_valid during RESP is accepted with no idle cycle.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Purpose: CPU load/store initiator for a word-organised data memory; sub-word stores use read-modify-write.
// Latency: from accept edge, done in cycle 2 (load, word store), 3 (sub-word store) or 1 (fault); wait states add.
// Backpressure: mem_ready stalls RD/WR with a wait-count abort; requests arriving while busy are dropped.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_e;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  // Abort happens on the stalled cycle that would bring the count to TIMEOUT_CYCLES.
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        busy_q;
  logic        done_q;
  logic [1:0]  err_q;
  logic [31:0] load_data_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        accept;
  logic        req_fault;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  // Request acceptance and alignment/size legality of the incoming request.
  always_comb begin
    accept    = req_valid && !busy_q;
    req_fault = (req_size == 2'b11) ||
                ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane merge for sub-word stores, from the returned word.
  always_comb begin
    rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
    rd_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
    ld_ext  = mem_rdata;
    merged  = mem_rdata;
    case (size_q)
      SZ_BYTE: begin
        ld_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
        merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        ld_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
        merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        ld_ext = mem_rdata;
        merged = wdata_q;
      end
    endcase
  end

  // Main FSM: all outputs are registered so the memory side stays stable across wait states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      load_data_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_fault) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= ERR_ALIGN;
            end else begin
              wait_cnt_q <= 8'd0;
              busy_q     <= 1'b1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {2'b00, req_addr[31:2]};
              if (req_we && (req_size == SZ_WORD)) begin
                state_q     <= ST_WR;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
              end else begin
                state_q  <= ST_RD;
                mem_we_q <= 1'b0;
              end
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (mem_ready) begin
            wait_cnt_q <= 8'd0;
            if (we_q) begin
              state_q     <= ST_WR;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= merged;
            end else begin
              state_q     <= ST_RESP;
              load_data_q <= ld_ext;
              busy_q      <= 1'b0;
              mem_req_q   <= 1'b0;
              done_q      <= 1'b1;
              err_q       <= ERR_OK;
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= ST_RESP;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= ERR_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ST_WR: begin
          if (mem_ready) begin
            wait_cnt_q <= 8'd0;
            state_q    <= ST_RESP;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= ERR_OK;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= ST_RESP;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= ERR_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios, then randomized loads/stores vs a byte-level model.
// A behavioural word memory with programmable wait states answers the DUT's memory port.
// Timeout parameter is set to 4 so the abort path is reached quickly.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        busy, done, mem_req, mem_we;
  logic [1:0]  err;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory ----------------
  logic [31:0] mem [0:63];
  int  wait_cfg = 0;
  int  wcnt = 0;
  bit  stall = 0;
  bit  stall_wr = 0;
  int  n_rd = 0, n_wr = 0, n_req_cyc = 0;
  logic [31:0] last_raddr = 0, last_waddr = 0;

  always @(negedge clk) begin
    if (mem_req && !stall && !(stall_wr && mem_we)) begin
      if (wcnt >= wait_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[5:0]];
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) wcnt = 0;
    end
  end

  bit          prev_stall = 0;
  logic [64:0] prev_side = '0;
  always @(posedge clk) begin
    if (mem_req) n_req_cyc++;
    if (prev_stall && mem_req) begin
      n_assert++;
      assert ({mem_we, mem_addr, mem_wdata} === prev_side) else begin
        n_fail++;
        $error("FAIL stable_mem_side observed %h expected %h", {mem_we, mem_addr, mem_wdata}, prev_side);
      end
    end
    prev_stall = mem_req && !mem_ready;
    prev_side  = {mem_we, mem_addr, mem_wdata};
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[5:0]] = mem_wdata;
        last_waddr = mem_addr;
        n_wr++;
      end else begin
        last_raddr = mem_addr;
        n_rd++;
      end
      wcnt = 0;
    end
  end

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int size, input bit sgn,
                                           input int unsigned addr);
    int     nb;
    longint v, lim;
    if (size == 2) return w;
    nb  = (size == 0) ? 1 : 2;
    lim = longint'(1) << (8 * nb);
    v   = longint'(w >> (8 * (addr % 4))) % lim;
    if (sgn && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input int size, input int unsigned addr);
    int     nb, sh;
    longint mask;
    if (size == 2) return wd;
    nb   = (size == 0) ? 1 : 2;
    sh   = 8 * int'(addr % 4);
    mask = ((longint'(1) << (8 * nb)) - 1) << sh;
    return 32'((longint'(old) & ~mask) | ((longint'(wd) << sh) & mask));
  endfunction

  function automatic bit ref_fault(input int size, input int unsigned addr);
    return (size == 3) || (size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a request now, accepts it on the next edge, returns cycles until done is seen.
  task automatic do_req(input bit we, input int size, input bit sgn, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
    req_we = we; req_size = 2'(size); req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, rd0, wr0, rq0;
  logic [31:0] ld_keep;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    #12;
    chk("reset_outputs", {busy, done, err, load_data, mem_req, mem_we, mem_addr, mem_wdata}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. word load
    mem[4] = 32'hDEADBEEF;
    do_req(0, 2, 0, 32'h10, 0, lat);
    chk("t1_lat", lat, 2);
    chk("t1_addr", last_raddr, 32'h4);
    chk("t1_data", load_data, 32'hDEADBEEF);
    chk("t1_err", err, 0);

    // 2. extension
    mem[4] = 32'h80FF7F01;
    do_req(0, 0, 1, 32'h13, 0, lat);
    chk("t2_sbyte", load_data, 32'hFFFFFF80);
    do_req(0, 1, 0, 32'h12, 0, lat);
    chk("t2_uhalf", load_data, 32'h000080FF);

    // 3. byte store RMW
    mem[8] = 32'h11223344;
    rd0 = n_rd; wr0 = n_wr;
    do_req(1, 0, 0, 32'h21, 32'hAA, lat);
    chk("t3_lat", lat, 3);
    chk("t3_word", mem[8], 32'h1122AA44);
    chk("t3_waddr", last_waddr, 32'h8);
    chk("t3_counts", {n_rd - rd0, n_wr - wr0}, {32'd1, 32'd1});

    // 4. faults
    ld_keep = load_data; rq0 = n_req_cyc;
    do_req(0, 2, 0, 32'h02, 0, lat);
    chk("t4_word_err", {err, 8'(lat)}, {2'b01, 8'd1});
    do_req(1, 1, 0, 32'h05, 32'h1234, lat);
    chk("t4_half_err", {err, 8'(lat)}, {2'b01, 8'd1});
    chk("t4_no_req", n_req_cyc - rq0, 0);
    chk("t4_ld_keep", load_data, ld_keep);

    // 5. timeout, then 3 wait states just under the limit
    stall = 1; rq0 = n_req_cyc;
    do_req(0, 2, 0, 32'h40, 0, lat);
    chk("t5_to_err", err, 2'b10);
    chk("t5_req_cycles", n_req_cyc - rq0, 4);
    chk("t5_to_lat", lat, 5);
    chk("t5_ld_keep", load_data, ld_keep);
    stall = 0; wait_cfg = 3;
    mem[16] = 32'hCAFEF00D;
    do_req(0, 2, 0, 32'h40, 0, lat);
    chk("t5_wait_ok", {err, 8'(lat)}, {2'b00, 8'd5});
    chk("t5_wait_data", load_data, 32'hCAFEF00D);
    wait_cfg = 0;

    // 6. reset while in WR of an RMW store
    stall_wr = 1; wr0 = n_wr; ld_keep = mem[3];
    req_we = 1; req_size = 0; req_signed = 0; req_addr = 32'h0D; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_in_wr", {mem_req, mem_we}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {busy, done, err, load_data, mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk("t6_no_write", {n_wr - wr0, mem[3]}, {32'd0, ld_keep});
    @(negedge clk); rst_n = 1'b1; stall_wr = 0;
    @(posedge clk); #1;
    mem[5] = 32'h0BADC0DE;
    do_req(0, 2, 0, 32'h14, 0, lat);
    chk("t6_after_reset", {err, 8'(lat), load_data}, {2'b00, 8'd2, 32'h0BADC0DE});

    // back-to-back: second request issued while done (RESP) is showing
    mem[6] = 32'h01020304;
    req_we = 0; req_size = 2; req_signed = 0; req_addr = 32'h18; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("b2b_accepted", {busy, mem_req, mem_addr}, {1'b1, 1'b1, 32'h6});
    @(posedge clk); #1;
    chk("b2b_done", {done, err, load_data}, {1'b1, 2'b00, 32'h01020304});

    // randomized traffic against the model
    begin
      logic [31:0] refm [0:63];
      for (int i = 0; i < 64; i++) refm[i] = mem[i];
      for (int t = 0; t < 60; t++) begin
        int sel, size, w, exp_lat, idx;
        bit we, sgn;
        int unsigned addr;
        logic [31:0] wd, exp_ld;
        logic [1:0]  exp_err;
        sel  = $urandom_range(0, 7);
        size = (sel < 3) ? 0 : (sel < 5) ? 1 : (sel < 7) ? 2 : 3;
        we   = $urandom_range(0, 1);
        sgn  = $urandom_range(0, 1);
        addr = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0 && size != 3) addr = addr & ~((size == 2) ? 3 : (size == 1) ? 1 : 0);
        wd   = $urandom;
        w    = $urandom_range(0, 2);
        wait_cfg = w;
        idx  = int'(addr / 4);
        exp_ld = load_data;
        if (ref_fault(size, addr)) begin
          exp_err = 2'b01; exp_lat = 1;
        end else begin
          exp_err = 2'b00;
          if (!we) begin
            exp_lat = 2 + w;
            exp_ld  = ref_load(refm[idx], size, sgn, addr);
          end else begin
            exp_lat = (size == 2) ? 2 + w : 3 + 2 * w;
            refm[idx] = ref_store(refm[idx], wd, size, addr);
          end
        end
        do_req(we, size, sgn, addr, wd, lat);
        chk("rnd_err", err, exp_err);
        chk("rnd_lat", lat, exp_lat);
        chk("rnd_load_data", load_data, exp_ld);
        chk("rnd_mem_word", mem[idx], refm[idx]);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
